// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared state encoding, default geometry and pipe-depth helper for text_row_sched
package text_pkg;

  // Scheduler states: wait for start, issue text-buffer reads, wait for the pipe to empty
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Default geometry
  localparam int COLS_DEF      = 80;
  localparam int ROWS_DEF      = 30;
  localparam int HEIGHT_DEF    = 16;
  localparam int WIDTH_DEF     = 8;
  localparam int UCPW_DEF      = 21;
  localparam int GLYPH_LAT_DEF = 4;

  // Derived widths for the default geometry
  localparam int COLW  = $clog2(COLS_DEF);
  localparam int ROWW  = $clog2(ROWS_DEF);
  localparam int LINEW = $clog2(HEIGHT_DEF);
  localparam int TBAW  = $clog2(COLS_DEF * ROWS_DEF);

  // One cycle of text-buffer read plus the glyph unit latency
  localparam int PIPE_D = 1 + GLYPH_LAT_DEF;

  function automatic int pipe_depth(input int glyph_lat);
    return 1 + glyph_lat;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - fixed-depth shift register with asynchronous active-low clear
module valid_delay #(
  parameter int DEPTH = 5,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stages [DEPTH];

  // Shift one stage per cycle; reset empties every stage so in-flight entries vanish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/text_row_sched.sv
// rtl/text_row_sched.sv - walks one text row through the glyph pipe into the line buffer (optional cursor: TEXT_CURSOR_EN)
module text_row_sched
  import text_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int UCPW      = UCPW_DEF,
  parameter int GLYPH_LAT = GLYPH_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(ROWS)-1:0]       row,
  input  logic [$clog2(HEIGHT)-1:0]     line_id,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(COLS*ROWS)-1:0]  tb_addr,
  input  logic [UCPW-1:0]               tb_data,
  output logic [UCPW-1:0]               glyph_ucp,
  output logic [$clog2(HEIGHT)-1:0]     glyph_line,
  input  logic [WIDTH-1:0]              glyph_pix,
`ifdef TEXT_CURSOR_EN
  input  logic                          cursor_on,
  input  logic [$clog2(COLS)-1:0]       cursor_col,
  input  logic [$clog2(ROWS)-1:0]       cursor_row,
`endif
  output logic                          lb_we,
  output logic [$clog2(COLS)-1:0]       lb_addr,
  output logic [WIDTH-1:0]              lb_data
);

  localparam int CW  = $clog2(COLS);
  localparam int AW  = $clog2(COLS * ROWS);
  localparam int PD  = pipe_depth(GLYPH_LAT);
  localparam int PW  = CW + 2;   // {valid, col, cursor hit}
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  state_t        state, next_state;
  logic [AW-1:0] base;
  logic [CW-1:0] col;
  logic          start_ok;
  logic          fetching;
  logic          hit;
  logic [PW-1:0] pipe_in, pipe_out;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic          out_hit;
  logic          last_wr;

  assign start_ok  = (state == IDLE) && start && (32'(row) < ROWS);
  assign fetching  = (state == FETCH);
  assign out_valid = pipe_out[PW-1];
  assign out_col   = pipe_out[CW:1];
  assign out_hit   = pipe_out[0];
  assign last_wr   = out_valid && (out_col == LAST_COL);

`ifdef TEXT_CURSOR_EN
  logic          cur_hit_en;
  logic [CW-1:0] cur_col;

  // Cursor decision is latched with the request so it stays fixed for the whole row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_hit_en <= 1'b0;
      cur_col    <= '0;
    end else if (start_ok) begin
      cur_hit_en <= cursor_on && (cursor_row == row);
      cur_col    <= cursor_col;
    end
  end

  assign hit = fetching && cur_hit_en && (col == cur_col);
`else
  assign hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: leave FETCH after the last column, leave DRAIN on the last write
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = FETCH;
      FETCH:   if (col == LAST_COL) next_state = DRAIN;
      DRAIN:   if (last_wr) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Row base, column counter and line index; base is multiplied once per request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      col        <= '0;
      glyph_line <= '0;
    end else if (start_ok) begin
      base       <= AW'(row) * AW'(COLS);
      col        <= '0;
      glyph_line <= line_id;
    end else if (fetching && (col != LAST_COL)) begin
      col <= col + 1'b1;
    end
  end

  // done marks the cycle after the final line-buffer write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == DRAIN) && last_wr;
  end

  assign pipe_in = {fetching, col, hit};

  valid_delay #(
    .DEPTH (PD),
    .W     (PW)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pipe_in),
    .q     (pipe_out)
  );

  assign busy      = (state != IDLE);
  assign tb_addr   = base + AW'(col);
  assign glyph_ucp = tb_data;
  assign lb_we     = out_valid;
  assign lb_addr   = out_col;
  assign lb_data   = !out_valid ? '0 : (out_hit ? ~glyph_pix : glyph_pix);

endmodule

// File: tb/tb_text_row_sched.sv
// tb/tb_text_row_sched.sv - scoreboard bench for text_row_sched (COLS=4, ROWS=3, GLYPH_LAT=4)
module tb_text_row_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  row;
  logic [3:0]  line_id;
  logic        busy, done;
  logic [3:0]  tb_addr;
  logic [20:0] tb_data;
  logic [20:0] glyph_ucp;
  logic [3:0]  glyph_line;
  logic [7:0]  glyph_pix;
  logic        lb_we;
  logic [1:0]  lb_addr;
  logic [7:0]  lb_data;
`ifdef TEXT_CURSOR_EN
  logic        cursor_on;
  logic [1:0]  cursor_col;
  logic [1:0]  cursor_row;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  logic [9:0] exp_q [$];
  logic [7:0] gp [4];

  always #5 clk = ~clk;

  text_row_sched #(
    .COLS(4), .ROWS(3), .HEIGHT(16), .WIDTH(8), .UCPW(21), .GLYPH_LAT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .row        (row),
    .line_id    (line_id),
    .busy       (busy),
    .done       (done),
    .tb_addr    (tb_addr),
    .tb_data    (tb_data),
    .glyph_ucp  (glyph_ucp),
    .glyph_line (glyph_line),
    .glyph_pix  (glyph_pix),
`ifdef TEXT_CURSOR_EN
    .cursor_on  (cursor_on),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
`endif
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data)
  );

  // Text buffer: 1-cycle read, content 'h41 + address
  always @(posedge clk) tb_data <= 21'h41 + 21'(tb_addr);

  // Glyph unit: {ucp[3:0], line} after 4 cycles
  always @(posedge clk) begin
    gp[0] <= {glyph_ucp[3:0], glyph_line};
    gp[1] <= gp[0];
    gp[2] <= gp[1];
    gp[3] <= gp[2];
  end
  assign glyph_pix = gp[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected writes of one row: data = {low nibble of 'h41+row*4+col, line}, optionally inverted at inv_col
  task automatic push_row(input int r, input int ln, input int inv_col);
    for (int c = 0; c < 4; c++) begin
      logic [7:0] code;
      logic [7:0] d;
      code = 8'(8'h41 + r * 4 + c);
      d = {code[3:0], 4'(ln)};
      if (c == inv_col) d = ~d;
      exp_q.push_back({2'(c), d});
    end
  endtask

  // Monitor: every line-buffer write is popped against the scoreboard
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (lb_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL write_unexpected: got addr %0h data %0h expected no write", lb_addr, lb_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("write_addr_data", {22'd0, lb_addr, lb_data}, {22'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, w0;
    logic any_busy, any_we, any_done;
    rst_n = 1'b0; start = 1'b0; row = '0; line_id = '0;
`ifdef TEXT_CURSOR_EN
    cursor_on = 1'b0; cursor_col = '0; cursor_row = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lb_we", lb_we, 0);
    chk("rst_tb_addr", tb_addr, 0);
    chk("rst_lb_addr", lb_addr, 0);
    chk("rst_lb_data", lb_data, 0);
    chk("rst_glyph_line", glyph_line, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single run: row 1, line 3
    @(negedge clk);
    start = 1'b1; row = 2'd1; line_id = 4'd3;
    exp_q.push_back({2'd0, 8'h53});
    exp_q.push_back({2'd1, 8'h63});
    exp_q.push_back({2'd2, 8'h73});
    exp_q.push_back({2'd3, 8'h83});
    d0 = done_cnt;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("busy_t%0d", k), busy, (k <= 9) ? 1 : 0);
      chk($sformatf("done_t%0d", k), done, (k == 10) ? 1 : 0);
      chk($sformatf("lb_we_t%0d", k), lb_we, (k >= 6 && k <= 9) ? 1 : 0);
      if (k <= 4) chk($sformatf("tb_addr_t%0d", k), tb_addr, 32'(3 + k));
      if (k <= 9) chk($sformatf("glyph_line_t%0d", k), glyph_line, 3);
    end
    chk("single_done_count", done_cnt - d0, 1);

    // Overlap: start at 0, ignored start at 3, accepted start in the done cycle
    @(negedge clk);
    start = 1'b1; row = 2'd0; line_id = 4'd5;
    push_row(0, 5, -1);
    d0 = done_cnt; w0 = wr_cnt;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 3) begin start = 1'b1; row = 2'd2; end
      if (k == 10) begin
        chk("overlap_done_t10", done, 1);
        start = 1'b1; row = 2'd2; line_id = 4'd1;
        push_row(2, 1, -1);
      end
    end
    chk("overlap_writes", wr_cnt - w0, 8);
    chk("overlap_dones", done_cnt - d0, 2);

    // Out-of-range row is ignored
    @(negedge clk);
    start = 1'b1; row = 2'd3; line_id = 4'd2;
    any_busy = 0; any_we = 0; any_done = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      any_busy |= busy; any_we |= lb_we; any_done |= done;
    end
    chk("bad_row_busy", any_busy, 0);
    chk("bad_row_we", any_we, 0);
    chk("bad_row_done", any_done, 0);

    // Reset in the middle of a run
    @(negedge clk);
    start = 1'b1; row = 2'd1; line_id = 4'd3;
    exp_q.push_back({2'd0, 8'h53});
    d0 = done_cnt; w0 = wr_cnt;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_lb_we", lb_we, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_writes", wr_cnt - w0, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    start = 1'b1; row = 2'd2; line_id = 4'd7;
    push_row(2, 7, -1);
    d0 = done_cnt;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("after_abort_done", done_cnt - d0, 1);

`ifdef TEXT_CURSOR_EN
    // Cursor on row 2, column 1
    cursor_on = 1'b1; cursor_row = 2'd2; cursor_col = 2'd1;
    @(negedge clk);
    start = 1'b1; row = 2'd2; line_id = 4'd0;
    push_row(2, 0, 1);
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b1; row = 2'd0; line_id = 4'd0;
    push_row(0, 0, -1);
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
